// File: rtl/onehot_decoder_seq_pkg.sv
// Shared widths, FSM state encoding and code-to-one-hot helper for the decoder.
package onehot_decoder_seq_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Turn a binary index into its one-hot line.
    function automatic logic [ONEHOT_W-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
        return ONEHOT_W'(1) << code;
    endfunction

endpackage

// File: rtl/code_hold_buf.sv
// One-entry code register with full flag; ready is simply "not full".
module code_hold_buf
    import onehot_decoder_seq_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [CODE_W-1:0] wr_code_i,
    input  logic              rd_en_i,
    output logic [CODE_W-1:0] rd_code_o,
    output logic              full_o,
    output logic              ready_c
);

    logic              full_q, full_d;
    logic [CODE_W-1:0] code_q, code_d;

    // Writes only land in an empty slot; reads only drain a full one.
    always_comb begin
        full_d = full_q;
        code_d = code_q;
        if (wr_en_i && !full_q) begin
            full_d = 1'b1;
            code_d = wr_code_i;
        end else if (rd_en_i && full_q) begin
            full_d = 1'b0;
        end
    end

    // Storage and flag registers; reset discards any held code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            code_q <= '0;
        end else begin
            full_q <= full_d;
            code_q <= code_d;
        end
    end

    assign rd_code_o = code_q;
    assign full_o    = full_q;
    assign ready_c   = !full_q;

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequenced 3-to-8 decoder: each accepted code drives its one-hot line for
// HOLD_CYCLES, then GAP_CYCLES of zeros; a one-entry buffer covers back-to-back codes.
module onehot_decoder_seq
    import onehot_decoder_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic [CODE_W-1:0]   Code,
    input  logic                In_valid,
    output logic                In_ready,
    output logic [ONEHOT_W-1:0] Data,
    output logic                Out_active,
    output logic                Done
);

    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'((GAP_CYCLES == 0) ? 0 : (GAP_CYCLES - 1));

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ONEHOT_W-1:0] data_q, data_d;
    logic                active_q, active_d;
    logic                done_q, done_d;

    logic                transfer;
    logic                buf_wr, buf_rd, buf_full, buf_ready;
    logic [CODE_W-1:0]   buf_code;
    logic                load;
    logic [CODE_W-1:0]   load_code;

    assign transfer = In_valid && buf_ready;

    // In IDLE the code bypasses the buffer; otherwise it is parked there.
    assign buf_wr = transfer && (state_q != ST_IDLE);

    code_hold_buf u_buf (
        .clk_i     (Clock),
        .rst_ni    (Resetn),
        .wr_en_i   (buf_wr),
        .wr_code_i (Code),
        .rd_en_i   (buf_rd),
        .rd_code_o (buf_code),
        .full_o    (buf_full),
        .ready_c   (buf_ready)
    );

    // Next-state, counter and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        buf_rd    = 1'b0;
        load      = 1'b0;
        load_code = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (buf_full) begin
                    load      = 1'b1;
                    load_code = buf_code;
                    buf_rd    = 1'b1;
                end else if (transfer) begin
                    load      = 1'b1;
                    load_code = Code;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP_CYCLES != 0) begin
                    data_d  = '0;
                    cnt_d   = GAP_RELOAD;
                    state_d = ST_GAP;
                end else if (buf_full) begin
                    load      = 1'b1;
                    load_code = buf_code;
                    buf_rd    = 1'b1;
                end else begin
                    data_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (buf_full) begin
                    load      = 1'b1;
                    load_code = buf_code;
                    buf_rd    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                data_d  = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            data_d  = code_to_onehot(load_code);
            cnt_d   = HOLD_RELOAD;
            state_d = ST_HOLD;
        end

        done_d   = (state_d == ST_HOLD) && (cnt_d == '0);
        active_d = (data_d != '0);
    end

    // State, counter and registered outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign In_ready   = buf_ready;
    assign Data       = data_q;
    assign Out_active = active_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: one instance with a gap, one without.
module tb_onehot_decoder_seq;
    import onehot_decoder_seq_pkg::*;

    logic       clk;
    logic       rst_n;

    logic [2:0] a_code;
    logic       a_valid, a_ready, a_act, a_done;
    logic [7:0] a_data;

    logic [2:0] b_code;
    logic       b_valid, b_ready, b_act, b_done;
    logic [7:0] b_data;

    int checks;
    int failures;

    onehot_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
        .Clock(clk), .Resetn(rst_n), .Code(a_code), .In_valid(a_valid),
        .In_ready(a_ready), .Data(a_data), .Out_active(a_act), .Done(a_done)
    );

    onehot_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut0 (
        .Clock(clk), .Resetn(rst_n), .Code(b_code), .In_valid(b_valid),
        .In_ready(b_ready), .Data(b_data), .Out_active(b_act), .Done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b1; a_code = 3'd5; b_valid = 1'b0; b_code = 3'd0;
        repeat (3) tick();
        checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", a_data); end
        checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", a_done); end
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
        checks++; if (a_act !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", a_act); end
        a_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL reset_no_transfer got=%h exp=00", a_data); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
    endtask

    task automatic test_single();
        a_code = 3'd5; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (a_data !== 8'h20) begin failures++; $display("FAIL single_data[%0d] got=%h exp=20", i, a_data); end
            checks++; if (a_done !== logic'(i == 3)) begin failures++; $display("FAIL single_done[%0d] got=%b exp=%b", i, a_done, i == 3); end
            checks++; if (a_act !== 1'b1) begin failures++; $display("FAIL single_active[%0d] got=%b exp=1", i, a_act); end
            tick();
        end
        checks++; if (a_data !== 8'h00 || a_done !== 1'b0) begin failures++; $display("FAIL single_gap got=%h/%b exp=00/0", a_data, a_done); end
        tick();
        checks++; if (dut.state_q !== ST_IDLE || a_data !== 8'h00) begin failures++; $display("FAIL single_idle state=%0d data=%h exp=IDLE/00", dut.state_q, a_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [9] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80};
        a_code = 3'd0; a_valid = 1'b1;
        tick();
        a_code = 3'd7;
        for (int k = 0; k < 9; k++) begin
            if (k == 1) a_valid = 1'b0;
            checks++; if (a_data !== exp_d[k]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, a_data, exp_d[k]); end
            if (k == 0 || k == 5 || k == 6) begin
                checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=1", k, a_ready); end
            end
            if (k == 1 || k == 4) begin
                checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=0", k, a_ready); end
            end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_zero_gap();
        logic [7:0] exp_d [9] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
        b_code = 3'd2; b_valid = 1'b1;
        tick();
        b_code = 3'd3;
        for (int k = 0; k < 9; k++) begin
            if (k == 1) b_valid = 1'b0;
            checks++; if (b_data !== exp_d[k]) begin failures++; $display("FAIL zgap_data[%0d] got=%h exp=%h", k, b_data, exp_d[k]); end
            checks++; if (b_done !== logic'(k == 3 || k == 7)) begin failures++; $display("FAIL zgap_done[%0d] got=%b exp=%b", k, b_done, k == 3 || k == 7); end
            tick();
        end
        repeat (2) tick();
    endtask

    task automatic test_reset_mid_hold();
        a_code = 3'd1; a_valid = 1'b1;
        tick();
        a_code = 3'd6;
        tick();
        a_valid = 1'b0;
        checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_full got=%b exp=0", a_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_data !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", a_data); end
        checks++; if (a_act !== 1'b0 || a_done !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b/%b exp=0/0", a_act, a_done); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            checks++; if (a_data !== 8'h00 || a_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_after[%0d] data=%h ready=%b exp=00/1", i, a_data, a_ready); end
            tick();
        end
    endtask

    task automatic test_sweep();
        int         exp_q[$];
        int         idx;
        int         cyc;
        logic [7:0] prev;
        logic [7:0] exp_oh;
        logic [7:0] one;
        int         code;
        idx = 0; cyc = 0; prev = 8'h00; one = 8'h01;
        while ((idx < 16 || exp_q.size() != 0 || a_data != 8'h00) && cyc < 600) begin
            checks++; if (a_act !== (a_data != 8'h00)) begin failures++; $display("FAIL sweep_active cyc=%0d got=%b data=%h", cyc, a_act, a_data); end
            if (a_data != 8'h00 && prev == 8'h00) begin
                checks++; if ($countones(a_data) != 1) begin failures++; $display("FAIL sweep_popcount cyc=%0d data=%h exp=1 bit", cyc, a_data); end
                if (exp_q.size() == 0) begin
                    failures++; checks++;
                    $display("FAIL sweep_extra cyc=%0d got=%h exp=none", cyc, a_data);
                end else begin
                    code = exp_q.pop_front();
                    exp_oh = one << code;
                    checks++; if (a_data !== exp_oh) begin failures++; $display("FAIL sweep_order cyc=%0d got=%h exp=%h", cyc, a_data, exp_oh); end
                end
            end else if (a_data != 8'h00) begin
                checks++; if (a_data !== prev) begin failures++; $display("FAIL sweep_hold cyc=%0d got=%h exp=%h", cyc, a_data, prev); end
            end
            prev = a_data;
            if (idx < 16) begin
                a_code  = 3'(idx % 8);
                a_valid = ($urandom_range(0, 2) != 0);
                if (a_valid && a_ready) begin
                    exp_q.push_back(idx % 8);
                    idx++;
                end
            end else begin
                a_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        a_valid = 1'b0;
        checks++; if (cyc >= 600) begin failures++; $display("FAIL sweep_timeout cyc=%0d limit=600", cyc); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sweep_leftover got=%0d exp=0", exp_q.size()); end
        checks++; if (idx != 16) begin failures++; $display("FAIL sweep_sent got=%0d exp=16", idx); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; a_valid = 1'b0; a_code = '0; b_valid = 1'b0; b_code = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_gap();
        test_reset_mid_hold();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
